// File: rtl/fxp64s_normalizer.sv
// fxp64s_normalizer: multi-cycle leading-one normalizer for fxp64s; define FXP64S_NORM_STICKY_EN for a sticky bit on right shifts
module fxp64s_normalizer (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic [63:0] out_shift,
  output logic        out_zero
);
  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;
  state_t state, state_nxt;
  logic s;
  logic [62:0] m, mag;
  logic [5:0] p, c, p_nxt, rsh;
  logic [2:0] k;
  logic [63:0] sh;
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  // probe one msb-index bit per cycle and derive the normalized result from the updated index
  always_comb begin
    c = p | (6'd1 << k);
    p_nxt = |(m >> c) ? c : p;
    sh = 64'd48 - {58'd0, p_nxt};
    rsh = p_nxt - 6'd48;
`ifdef FXP64S_NORM_STICKY_EN
    mag = sh[63] ? (m >> rsh) | {62'd0, |(m & ~({63{1'b1}} << rsh))} : m << sh[5:0];
`else
    mag = sh[63] ? m >> rsh : m << sh[5:0];
`endif
  end
  // next state: accept in IDLE, six search steps, hold result until downstream takes it
  always_comb begin
    state_nxt = state == IDLE ? (in_valid ? SEARCH : IDLE) :
                state == SEARCH ? (k == 3'd0 ? DONE : SEARCH) :
                (out_ready ? IDLE : DONE);
  end
  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= state_nxt;
  end
  // operand capture, search progress and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s <= 1'b0;
      m <= '0;
      p <= '0;
      k <= '0;
      out_data <= '0;
      out_shift <= '0;
      out_zero <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      s <= in_data[63];
      m <= in_data[62:0];
      p <= '0;
      k <= 3'd5;
    end else if (state == SEARCH) begin
      p <= p_nxt;
      k <= k - 3'd1;
      if (k == 3'd0) begin
        out_data <= {s, mag};
        out_shift <= m == '0 ? 64'd0 : sh;
        out_zero <= m == '0;
      end
    end
  end
endmodule

// File: tb/tb_fxp64s_normalizer.sv
// tb_fxp64s_normalizer: directed vectors plus backpressure and mid-search reset sequences
module tb_fxp64s_normalizer;
  logic clk = 1'b0;
  logic rst, in_valid, in_ready, out_valid, out_ready, out_zero;
  logic [63:0] in_data, out_data, out_shift;
  int checks = 0;
  int errors = 0;
`ifdef FXP64S_NORM_STICKY_EN
  localparam logic [63:0] STK = 64'd1;
`else
  localparam logic [63:0] STK = 64'd0;
`endif
  typedef struct packed {
    logic [63:0] din;
    logic [63:0] dout;
    logic [63:0] dsh;
    logic        dz;
  } vec_t;
  vec_t vecs [11];

  fxp64s_normalizer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_shift(out_shift), .out_zero(out_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic start(input logic [63:0] d);
    in_valid = 1'b1;
    in_data = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data = ~d;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int n;
    start(v.din);
    wait_done(n);
    chk($sformatf("latency[%0d]", idx), 64'(n), 64'd6);
    chk($sformatf("data[%0d]", idx), out_data, v.dout);
    chk($sformatf("shift[%0d]", idx), out_shift, v.dsh);
    chk($sformatf("zero[%0d]", idx), {63'd0, out_zero}, {63'd0, v.dz});
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk($sformatf("valid_drop[%0d]", idx), {63'd0, out_valid}, 64'd0);
    chk($sformatf("ready_rise[%0d]", idx), {63'd0, in_ready}, 64'd1);
  endtask

  initial begin
    logic [63:0] held_data, held_shift;
    int n;
    vecs[0]  = '{64'h0001_0000_0000_0000, 64'h0001_0000_0000_0000, 64'd0, 1'b0};
    vecs[1]  = '{64'h0000_0000_0000_0001, 64'h0001_0000_0000_0000, 64'd48, 1'b0};
    vecs[2]  = '{64'h8000_0000_0000_0003, 64'h8001_8000_0000_0000, 64'd47, 1'b0};
    vecs[3]  = '{64'h4000_0000_0000_0001, 64'h0001_0000_0000_0000 | STK, 64'hFFFF_FFFF_FFFF_FFF2, 1'b0};
    vecs[4]  = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'd0, 1'b1};
    vecs[5]  = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h0001_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFF2, 1'b0};
    vecs[6]  = '{64'h0002_0000_0000_0000, 64'h0001_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
    vecs[7]  = '{64'h0000_8000_0000_0001, 64'h0001_0000_0000_0002, 64'd1, 1'b0};
    vecs[8]  = '{64'h0000_0000_0000_0000, 64'h0000_0000_0000_0000, 64'd0, 1'b1};
    vecs[9]  = '{64'h0003_0000_0000_0001, 64'h0001_8000_0000_0000 | STK, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
    vecs[10] = '{64'h0000_0000_0001_0000, 64'h0001_0000_0000_0000, 64'd32, 1'b0};
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_data = '0;
    #1;
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_out_shift", out_shift, 64'd0);
    chk("rst_out_zero", {63'd0, out_zero}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
    for (int i = 0; i < 11; i++) run_vec(vecs[i], i);
    start(vecs[2].din);
    wait_done(n);
    chk("bp_latency", 64'(n), 64'd6);
    held_data = out_data;
    held_shift = out_shift;
    chk("bp_data", held_data, vecs[2].dout);
    in_valid = 1'b1;
    in_data = 64'h0000_0000_0000_00FF;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("bp_valid[%0d]", i), {63'd0, out_valid}, 64'd1);
      chk($sformatf("bp_in_ready[%0d]", i), {63'd0, in_ready}, 64'd0);
      chk($sformatf("bp_data[%0d]", i), out_data, held_data);
      chk($sformatf("bp_shift[%0d]", i), out_shift, held_shift);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("bp_release_in_ready", {63'd0, in_ready}, 64'd1);
    repeat (7) @(posedge clk);
    #1;
    chk("bp_no_second_accept", {63'd0, out_valid}, 64'd0);
    start(vecs[5].din);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("mid_rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("mid_rst_out_data", out_data, 64'd0);
    #1;
    rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("mid_rst_no_result", {63'd0, out_valid}, 64'd0);
    run_vec(vecs[9], 99);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
